// File: rtl/execute.sv
// rtl/execute.sv - ASIP execute stage: scalar ALU with flags and compares, lane-wise 8-bit vector ALU, store-data select.
// All outputs are registered, which gives a fixed one-cycle latency.
module execute (
  input  logic         clk,
  input  logic         rst,
  input  logic         VCSub,
  input  logic         SelWriteData,
  input  logic         Rs1_sel,
  input  logic         Rs2_sel,
  input  logic [1:0]   SelectorOpA,
  input  logic [1:0]   SelectorOpB,
  input  logic [2:0]   ALUop,
  input  logic [31:0]  OpA,
  input  logic [31:0]  OpB,
  input  logic [31:0]  Imm,
  input  logic [255:0] OpAV,
  input  logic [255:0] OpBV,
  output logic         Zero,
  output logic         Carry,
  output logic         OverFlow,
  output logic         Negative,
  output logic         eq,
  output logic         bgt,
  output logic [31:0]  ALUresult,
  output logic [31:0]  WriteData,
  output logic [255:0] VALUresult
);

  logic [31:0]  w_a, w_b, w_res;
  logic [32:0]  w_sum, w_diff;
  logic         w_carry, w_ovf;
  logic [255:0] w_va, w_vb, w_vres;
  logic [2:0]   w_vop;
  logic [7:0]   w_la, w_lb;

  logic         r_zero, r_carry, r_ovf, r_neg, r_eq, r_bgt;
  logic [31:0]  r_res, r_wd;
  logic [255:0] r_vres;

  always_comb begin
    w_a = OpA;
    case (SelectorOpA)
      2'd0: w_a = OpA;
      2'd1: w_a = Imm;
      2'd2: w_a = 32'd0;
      2'd3: w_a = OpB;
      default: w_a = OpA;
    endcase
    w_b = OpB;
    case (SelectorOpB)
      2'd0: w_b = OpB;
      2'd1: w_b = Imm;
      2'd2: w_b = 32'd0;
      2'd3: w_b = OpA;
      default: w_b = OpB;
    endcase
  end

  // Subtract as A + ~B + 1 so bit 32 reads directly as "no borrow".
  assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
  assign w_diff = {1'b0, w_a} + {1'b0, ~w_b} + 33'd1;

  always_comb begin
    w_res   = 32'd0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (ALUop)
      3'd0: begin
        w_res   = w_sum[31:0];
        w_carry = w_sum[32];
        w_ovf   = (w_a[31] == w_b[31]) && (w_sum[31] != w_a[31]);
      end
      3'd1: begin
        w_res   = w_diff[31:0];
        w_carry = w_diff[32];
        w_ovf   = (w_a[31] != w_b[31]) && (w_diff[31] != w_a[31]);
      end
      3'd2: w_res = w_a & w_b;
      3'd3: w_res = w_a | w_b;
      3'd4: w_res = w_a ^ w_b;
      3'd5: w_res = w_a << w_b[4:0];
      3'd6: w_res = w_a >> w_b[4:0];
      3'd7: w_res = w_a * w_b;
      default: w_res = 32'd0;
    endcase
  end

  assign w_va  = Rs1_sel ? OpAV : {32{w_a[7:0]}};
  assign w_vb  = Rs2_sel ? OpBV : {32{w_b[7:0]}};
  assign w_vop = VCSub ? 3'd1 : ALUop;

  always_comb begin
    w_vres = '0;
    w_la   = 8'd0;
    w_lb   = 8'd0;
    for (int i = 0; i < 32; i++) begin
      w_la = w_va[8*i +: 8];
      w_lb = w_vb[8*i +: 8];
      case (w_vop)
        3'd0: w_vres[8*i +: 8] = w_la + w_lb;
        3'd1: w_vres[8*i +: 8] = w_la - w_lb;
        3'd2: w_vres[8*i +: 8] = w_la & w_lb;
        3'd3: w_vres[8*i +: 8] = w_la | w_lb;
        3'd4: w_vres[8*i +: 8] = w_la ^ w_lb;
        3'd5: w_vres[8*i +: 8] = w_la << w_lb[2:0];
        3'd6: w_vres[8*i +: 8] = w_la >> w_lb[2:0];
        3'd7: w_vres[8*i +: 8] = w_la * w_lb;
        default: w_vres[8*i +: 8] = 8'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_neg   <= 1'b0;
      r_eq    <= 1'b0;
      r_bgt   <= 1'b0;
      r_res   <= 32'd0;
      r_wd    <= 32'd0;
      r_vres  <= '0;
    end else begin
      r_zero  <= (w_res == 32'd0);
      r_carry <= w_carry;
      r_ovf   <= w_ovf;
      r_neg   <= w_res[31];
      r_eq    <= (w_a == w_b);
      r_bgt   <= ($signed(w_a) > $signed(w_b));
      r_res   <= w_res;
      r_wd    <= SelWriteData ? Imm : OpB;
      r_vres  <= w_vres;
    end
  end

  assign Zero       = r_zero;
  assign Carry      = r_carry;
  assign OverFlow   = r_ovf;
  assign Negative   = r_neg;
  assign eq         = r_eq;
  assign bgt        = r_bgt;
  assign ALUresult  = r_res;
  assign WriteData  = r_wd;
  assign VALUresult = r_vres;

endmodule

// File: tb/tb_execute.sv
// tb/tb_execute.sv - scoreboard bench for execute: directed and random stimulus against an arithmetic reference model.
module tb_execute;

  typedef struct packed {
    logic         vcsub, selwd, rs1, rs2;
    logic [1:0]   sela, selb;
    logic [2:0]   op;
    logic [31:0]  opa, opb, imm;
    logic [255:0] opav, opbv;
  } stim_t;

  typedef struct packed {
    logic [5:0]   flags;
    logic [31:0]  res, wd;
    logic [255:0] vres;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         VCSub, SelWriteData, Rs1_sel, Rs2_sel;
  logic [1:0]   SelectorOpA, SelectorOpB;
  logic [2:0]   ALUop;
  logic [31:0]  OpA, OpB, Imm;
  logic [255:0] OpAV, OpBV;
  logic         Zero, Carry, OverFlow, Negative, eq, bgt;
  logic [31:0]  ALUresult, WriteData;
  logic [255:0] VALUresult;

  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb_q[$];
  stim_t cur;

  always #5 clk = ~clk;

  execute dut (
    .clk(clk), .rst(rst), .VCSub(VCSub), .SelWriteData(SelWriteData),
    .Rs1_sel(Rs1_sel), .Rs2_sel(Rs2_sel), .SelectorOpA(SelectorOpA),
    .SelectorOpB(SelectorOpB), .ALUop(ALUop), .OpA(OpA), .OpB(OpB), .Imm(Imm),
    .OpAV(OpAV), .OpBV(OpBV), .Zero(Zero), .Carry(Carry), .OverFlow(OverFlow),
    .Negative(Negative), .eq(eq), .bgt(bgt), .ALUresult(ALUresult),
    .WriteData(WriteData), .VALUresult(VALUresult)
  );

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] own,
                                       input logic [31:0] imm, input logic [31:0] other);
    case (sel)
      2'd0: return own;
      2'd1: return imm;
      2'd2: return 32'd0;
      default: return other;
    endcase
  endfunction

  function automatic exp_t model(input stim_t s);
    exp_t e;
    logic [31:0] a, b;
    longint unsigned ua, ub, wide;
    longint sa, sb, sr;
    int x, y, lane, vop;
    logic c, v;
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;
    a = pick(s.sela, s.opa, s.imm, s.opb);
    b = pick(s.selb, s.opb, s.imm, s.opa);
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    c = 1'b0; v = 1'b0; wide = 0;
    case (s.op)
      3'd0: begin wide = ua + ub; c = (wide > 64'hFFFF_FFFF); sr = sa + sb; v = (sr > MAXS) || (sr < MINS); end
      3'd1: begin wide = ua - ub; c = (ua >= ub); sr = sa - sb; v = (sr > MAXS) || (sr < MINS); end
      3'd2: wide = ua & ub;
      3'd3: wide = ua | ub;
      3'd4: wide = ua ^ ub;
      3'd5: wide = ua << (ub % 32);
      3'd6: wide = ua >> (ub % 32);
      default: wide = ua * ub;
    endcase
    e.res = wide[31:0];
    e.flags = {e.res == 32'd0, c, v, e.res[31], a == b, sa > sb};
    e.wd = s.selwd ? s.imm : s.opb;
    vop = s.vcsub ? 1 : int'(s.op);
    for (int i = 0; i < 32; i++) begin
      x = s.rs1 ? int'(s.opav[8*i +: 8]) : int'(a[7:0]);
      y = s.rs2 ? int'(s.opbv[8*i +: 8]) : int'(b[7:0]);
      case (vop)
        0: lane = (x + y) % 256;
        1: lane = (x - y + 256) % 256;
        2: lane = x & y;
        3: lane = x | y;
        4: lane = x ^ y;
        5: lane = (x << (y % 8)) % 256;
        6: lane = x >> (y % 8);
        default: lane = (x * y) % 256;
      endcase
      e.vres[8*i +: 8] = lane[7:0];
    end
    return e;
  endfunction

  task automatic apply(input stim_t s);
    VCSub = s.vcsub; SelWriteData = s.selwd; Rs1_sel = s.rs1; Rs2_sel = s.rs2;
    SelectorOpA = s.sela; SelectorOpB = s.selb; ALUop = s.op;
    OpA = s.opa; OpB = s.opb; Imm = s.imm; OpAV = s.opav; OpBV = s.opbv;
  endtask

  task automatic issue(input stim_t s);
    @(negedge clk);
    apply(s);
    sb_q.push_back(model(s));
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.vcsub = ($urandom_range(0, 3) == 0);
    s.selwd = $urandom_range(0, 1);
    s.rs1 = $urandom_range(0, 1);
    s.rs2 = $urandom_range(0, 1);
    s.sela = $urandom_range(0, 3);
    s.selb = $urandom_range(0, 3);
    s.op = $urandom_range(0, 7);
    s.opa = $urandom();
    s.opb = ($urandom_range(0, 4) == 0) ? s.opa : $urandom();
    s.imm = $urandom();
    for (int i = 0; i < 8; i++) begin
      s.opav[32*i +: 32] = $urandom();
      s.opbv[32*i +: 32] = $urandom();
    end
    return s;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  task automatic check_zero(input string name);
    check(name, {Zero, Carry, OverFlow, Negative, eq, bgt, ALUresult, WriteData, VALUresult}, '0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("flags", {250'd0, Zero, Carry, OverFlow, Negative, eq, bgt}, {250'd0, e.flags});
        check("ALUresult", {224'd0, ALUresult}, {224'd0, e.res});
        check("WriteData", {224'd0, WriteData}, {224'd0, e.wd});
        check("VALUresult", VALUresult, e.vres);
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    int waited;
    rst = 1'b1;
    apply(rand_stim());
    #3;
    check_zero("reset_async");
    repeat (3) begin
      @(negedge clk);
      apply(rand_stim());
    end
    #1;
    check_zero("reset_hold");
    @(negedge clk);
    rst = 1'b0;

    s = '0;
    s.opa = 32'd1234; s.opb = 32'd9999; s.imm = 32'd100;
    s.opav = 256'hABCD; s.opbv = 256'h1234; s.rs1 = 1'b1; s.rs2 = 1'b1;
    issue(s);
    s.sela = 2'd1; issue(s);
    s.selb = 2'd1; issue(s);
    s.sela = 2'd0; s.selb = 2'd0; s.op = 3'd1; issue(s);
    s.opa = 32'h8000_0000; s.opb = 32'd1; issue(s);
    s.opa = 32'd1234; s.opb = 32'd9999;
    s.op = 3'd0; s.vcsub = 1'b1; issue(s);
    s.vcsub = 1'b0; s.rs1 = 1'b0; s.op = 3'd1; issue(s);
    s.selwd = 1'b1; s.sela = 2'd3; s.selb = 2'd2; issue(s);
    s.op = 3'd0; s.opa = 32'hFFFF_FFFF; s.opb = 32'd1; s.sela = 2'd0; s.selb = 2'd0; issue(s);
    s.opa = 32'h7FFF_FFFF; issue(s);

    for (int i = 0; i < 200; i++) issue(rand_stim());

    @(negedge clk);
    apply(rand_stim());
    #2;
    rst = 1'b1;
    #1;
    check_zero("reset_midstream");
    @(negedge clk);
    check_zero("reset_midstream_hold");
    rst = 1'b0;

    for (int i = 0; i < 100; i++) issue(rand_stim());

    waited = 0;
    while (sb_q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d results still pending, expected 0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
